// File: rtl/snake_pkg.sv
// Shared map geometry, tile encoding and map_writer types for the snake game.
package snake_pkg;

    localparam int unsigned MAP_W   = 20;
    localparam int unsigned MAP_H   = 15;
    localparam int unsigned MAP_X_B = 5;
    localparam int unsigned MAP_Y_B = 4;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        WALL   = 3'd1,
        SNAKE1 = 3'd2,
        SNAKE2 = 3'd3,
        POINT  = 3'd4
    } tile_t;

    typedef struct packed {
        logic [MAP_X_B-1:0] x;
        logic [MAP_Y_B-1:0] y;
        tile_t              tile;
    } map_req_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StClear = 2'd2
    } wr_state_e;

    localparam logic [MAP_Y_B-1:0] LAST_ROW = MAP_Y_B'(MAP_H - 1);

    // Tile written at (row, col) by a full-map clear: WALL on the border, EMPTY inside.
    function automatic tile_t clear_tile(input logic [MAP_Y_B-1:0] row, input int unsigned col);
        return (row == '0 || row == LAST_ROW || col == 0 || col == MAP_W - 1) ? WALL : EMPTY;
    endfunction

endpackage

// File: rtl/map_if.sv
// Tile array shared between map_writer (sole writer) and the draw logic.
interface map_if;
    import snake_pkg::*;

    tile_t [MAP_H-1:0][MAP_W-1:0] tiles;

    modport writer (output tiles);
    modport reader (input tiles);
endinterface

// File: rtl/map_req_fifo.sv
// Synchronous request FIFO with wrap-bit pointers and a single-cycle flush.
module map_req_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        rdata_o = mem_q[rptr_q[AW-1:0]];
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + (AW + 1)'(do_push);
            rptr_d = rptr_q + (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/map_writer.sv
// Sole writer of the tile map: queues tile writes, commits them during vblank,
// and performs row-by-row full-map clears.
module map_writer
    import snake_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblank,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MAP_X_B-1:0] req_x,
    input  logic [MAP_Y_B-1:0] req_y,
    input  tile_t              req_tile,
    input  logic               clear,
    output logic               busy,
    output logic               err,
    map_if.writer              map
);
    localparam int unsigned ReqW = $bits(map_req_t);

    wr_state_e state_q, state_d;

    logic                         init_q, init_d;
    logic                         err_q, err_d;
    logic                         wr_valid_q, wr_valid_d;
    map_req_t                     wr_req_q, wr_req_d;
    logic [MAP_Y_B-1:0]           row_q, row_d;
    tile_t [MAP_H-1:0][MAP_W-1:0] tiles_q, tiles_d;

    logic            push, pop, row_wr, in_range;
    logic            fifo_full, fifo_empty;
    logic [ReqW-1:0] fifo_rdata;
    map_req_t        head;

    map_req_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (ReqW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (clear),
        .push_i  (push),
        .wdata_i ({req_x, req_y, req_tile}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StDrain;
            StDrain: if (fifo_empty) state_d = StIdle;
            StClear: if (vblank && row_q == LAST_ROW) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (clear) state_d = StClear;
    end

    // Popping straight from IDLE keeps acceptance-to-commit at two edges.
    always_comb begin
        req_ready = init_q && !fifo_full && (state_q != StClear) && !clear;
        busy      = (state_q == StClear) || !fifo_empty;
        push      = req_valid && req_ready;
        pop       = vblank && !fifo_empty && (state_q != StClear) && !clear;
        row_wr    = vblank && (state_q == StClear) && !clear;
    end

    always_comb begin
        head       = map_req_t'(fifo_rdata);
        in_range   = (32'(head.x) < MAP_W) && (32'(head.y) < MAP_H);
        init_d     = 1'b1;
        wr_valid_d = pop && in_range;
        wr_req_d   = pop ? head : wr_req_q;
        err_d      = err_q || (pop && !in_range);
        row_d      = row_q;
        if (clear) begin
            row_d = '0;
        end else if (row_wr) begin
            row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end

        tiles_d = tiles_q;
        if (wr_valid_q) begin
            tiles_d[wr_req_q.y][wr_req_q.x] = wr_req_q.tile;
        end
        if (row_wr) begin
            for (int unsigned c = 0; c < MAP_W; c++) begin
                tiles_d[row_q][MAP_X_B'(c)] = clear_tile(row_q, c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_req_q   <= '0;
            row_q      <= '0;
            for (int unsigned r = 0; r < MAP_H; r++) begin
                for (int unsigned c = 0; c < MAP_W; c++) begin
                    tiles_q[MAP_Y_B'(r)][MAP_X_B'(c)] <= EMPTY;
                end
            end
        end else begin
            init_q     <= init_d;
            err_q      <= err_d;
            wr_valid_q <= wr_valid_d;
            wr_req_q   <= wr_req_d;
            row_q      <= row_d;
            tiles_q    <= tiles_d;
        end
    end

    assign err       = err_q;
    assign map.tiles = tiles_q;

endmodule

// File: tb/tb_map_writer.sv
// Directed and randomized checks of map_writer against an end-state map model.
module tb_map_writer;
    import snake_pkg::*;

    typedef tile_t map_t [MAP_H][MAP_W];

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               vblank = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [MAP_X_B-1:0] req_x = '0;
    logic [MAP_Y_B-1:0] req_y = '0;
    tile_t              req_tile = EMPTY;
    logic               clear = 1'b0;
    logic               busy;
    logic               err;

    map_if u_map ();

    map_writer #(
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vblank    (vblank),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_tile  (req_tile),
        .clear     (clear),
        .busy      (busy),
        .err       (err),
        .map       (u_map)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    map_t exp_map;
    map_t pre_map;
    logic exp_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int map_diff(input map_t e);
        int n = 0;
        for (int y = 0; y < MAP_H; y++) begin
            for (int x = 0; x < MAP_W; x++) begin
                if (u_map.tiles[y][x] !== e[y][x]) n++;
            end
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int y = 0; y < MAP_H; y++)
            for (int x = 0; x < MAP_W; x++) exp_map[y][x] = EMPTY;
        exp_err = 1'b0;
    endtask

    task automatic model_clear();
        for (int y = 0; y < MAP_H; y++)
            for (int x = 0; x < MAP_W; x++)
                exp_map[y][x] = (y == 0 || y == MAP_H - 1 || x == 0 || x == MAP_W - 1) ?
                                WALL : EMPTY;
    endtask

    // Accepted requests land in acceptance order; out-of-range ones only raise err.
    task automatic model_apply(input int x, input int y, input tile_t t);
        if (x >= MAP_W || y >= MAP_H) exp_err = 1'b1;
        else exp_map[y][x] = t;
    endtask

    task automatic push(input int x, input int y, input tile_t t);
        int n = 0;
        req_valid = 1'b1;
        req_x     = MAP_X_B'(x);
        req_y     = MAP_Y_B'(y);
        req_tile  = t;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", int'(req_ready), 1);
        if (req_ready) model_apply(x, y, t);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(tag, int'(busy), 0);
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_ready", int'(req_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_map", map_diff(exp_map), 0);
        tick();
        tick();
        rst = 1'b0;
        check("ready_before_edge", int'(req_ready), 0);
        tick();
        check("ready_after_edge", int'(req_ready), 1);

        // Single push with two-edge commit latency
        vblank = 1'b1;
        push(3, 5, POINT);
        check("lat_edge0", int'(u_map.tiles[5][3]), int'(EMPTY));
        tick();
        check("lat_edge1", int'(u_map.tiles[5][3]), int'(EMPTY));
        tick();
        check("lat_edge2", int'(u_map.tiles[5][3]), int'(POINT));
        check("single_busy", int'(busy), 0);

        // Fill the FIFO outside vblank, then drain in order
        vblank  = 1'b0;
        pre_map = exp_map;
        for (int k = 0; k < 8; k++) push(k + 1, 1, tile_t'(3'(1 + k % 4)));
        check("full_ready", int'(req_ready), 0);
        check("held_map", map_diff(pre_map), 0);
        repeat (3) tick();
        check("held_map_later", map_diff(pre_map), 0);
        check("held_busy", int'(busy), 1);
        vblank = 1'b1;
        tick();
        check("order_pre", int'(u_map.tiles[1][1]), int'(EMPTY));
        for (int k = 0; k < 8; k++) begin
            tick();
            check("order_now", int'(u_map.tiles[1][k + 1]), int'(tile_t'(3'(1 + k % 4))));
            if (k < 7) check("order_next", int'(u_map.tiles[1][k + 2]), int'(EMPTY));
        end
        wait_idle("drain_busy");
        check("drain_map", map_diff(exp_map), 0);

        // Out-of-range request
        push(MAP_W, 0, WALL);
        wait_idle("oob_busy");
        check("oob_err", int'(err), int'(exp_err));
        check("oob_map", map_diff(exp_map), 0);

        // Same-tile overwrite
        push(2, 2, SNAKE1);
        push(2, 2, SNAKE2);
        wait_idle("ovw_busy");
        check("ovw_tile", int'(u_map.tiles[2][2]), int'(SNAKE2));
        check("ovw_map", map_diff(exp_map), 0);
        check("err_sticky", int'(err), 1);

        // Clear with queued entries and a coinciding request
        vblank = 1'b0;
        push(6, 6, POINT);
        push(7, 7, SNAKE1);
        push(8, 8, WALL);
        clear     = 1'b1;
        vblank    = 1'b1;
        req_valid = 1'b1;
        req_x     = MAP_X_B'(4);
        req_y     = MAP_Y_B'(4);
        req_tile  = POINT;
        #1;
        check("clear_blocks_ready", int'(req_ready), 0);
        tick();
        clear     = 1'b0;
        req_valid = 1'b0;
        model_clear();
        check("clear_busy", int'(busy), 1);
        repeat (MAP_H - 1) tick();
        check("clear_busy_last", int'(busy), 1);
        tick();
        check("clear_done_busy", int'(busy), 0);
        check("clear_map", map_diff(exp_map), 0);
        tick();
        check("clear_map_settled", map_diff(exp_map), 0);
        check("clear_err_kept", int'(err), 1);

        // Clear restart mid-clear, with vblank gating
        push(3, 3, SNAKE1);
        wait_idle("restart_pre_busy");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        vblank = 1'b0;
        repeat (3) tick();
        vblank = 1'b1;
        model_clear();
        repeat (MAP_H - 1) tick();
        check("restart_busy_last", int'(busy), 1);
        tick();
        check("restart_done_busy", int'(busy), 0);
        check("restart_map", map_diff(exp_map), 0);

        // Reset, then random traffic against the model
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        check("rerst_err", int'(err), 0);
        tick();
        for (int i = 0; i < 300; i++) begin
            int    rx, ry;
            tile_t rt;
            rx        = $urandom_range(0, MAP_W);
            ry        = $urandom_range(0, MAP_H);
            rt        = tile_t'(3'($urandom_range(0, 4)));
            vblank    = ($urandom_range(0, 3) != 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_x     = MAP_X_B'(rx);
            req_y     = MAP_Y_B'(ry);
            req_tile  = rt;
            if (req_valid && req_ready) model_apply(rx, ry, rt);
            tick();
        end
        req_valid = 1'b0;
        vblank    = 1'b1;
        wait_idle("rand_busy");
        check("rand_map", map_diff(exp_map), 0);
        check("rand_err", int'(err), int'(exp_err));

        // Asynchronous reset in the middle of a clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (4) tick();
        check("mid_clear_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_map", map_diff(exp_map), 0);
        check("async_busy", int'(busy), 0);
        check("async_ready", int'(req_ready), 0);
        check("async_err", int'(err), 0);
        #2;
        rst = 1'b0;
        tick();
        check("async_ready_after", int'(req_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
